// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the iteration-counter width helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cntWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_abs.sv
// Combinational conditional absolute value: in signed mode a negative operand
// is negated into an unsigned magnitude (the most negative value maps to 2^(WIDTH-1)).
module mul_abs #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] val,
    input  logic             is_signed,
    output logic [WIDTH-1:0] mag,
    output logic             sign
);

    assign sign = is_signed & val[WIDTH-1];
    assign mag  = sign ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier, one partial product per clock, start/ready
// handshake and one-cycle done pulse. Optional macro SEQ_MULT_EARLY_TERM_EN
// ends the iteration as soon as the remaining multiplier magnitude is zero.
module seq_shift_add_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = cntWidth(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] magA_q, magA_d;
    logic [PW-1:0]    magBSh_q, magBSh_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic [PW-1:0]    product_q, product_d;

    logic [WIDTH-1:0] absA, absB;
    logic             signA, signB;

    mul_abs #(.WIDTH(WIDTH)) uAbsA (
        .val       (multiplier),
        .is_signed (is_signed),
        .mag       (absA),
        .sign      (signA)
    );

    mul_abs #(.WIDTH(WIDTH)) uAbsB (
        .val       (multiplicand),
        .is_signed (is_signed),
        .mag       (absB),
        .sign      (signB)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            magA_q    <= '0;
            magBSh_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            magA_q    <= magA_d;
            magBSh_q  <= magBSh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        magA_d    = magA_q;
        magBSh_d  = magBSh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    magA_d   = absA;
                    magBSh_d = {{WIDTH{1'b0}}, absB};
                    neg_d    = signA ^ signB;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (magA_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    if (magA_q[0]) begin
                        acc_d = acc_q + magBSh_q;
                    end
                    magA_d   = magA_q >> 1;
                    magBSh_d = magBSh_q << 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
`else
                if (magA_q[0]) begin
                    acc_d = acc_q + magBSh_q;
                end
                magA_d   = magA_q >> 1;
                magBSh_d = magBSh_q << 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // This edge performs the final (WIDTH-th) iteration.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
`endif
            end

            ST_DONE: begin
                product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule
